// File: rtl/raymarch_pkg.sv
// -----------------------------------------------------------------------------
// raymarch_pkg
// Shared types and helpers for the sphere-tracing ray-march controller.
//   BITS / FIXED : word width and fraction bits of the Q16.16 format
//   vec3_t       : packed signed 3-component vector (x, y, z)
//   state_e      : controller state encoding
//   fx_mul       : Q16.16 multiply, full 64-bit product, >>>16, truncated
//   sat_add      : signed add that clamps on overflow instead of wrapping
// -----------------------------------------------------------------------------
package raymarch_pkg;

    localparam int BITS  = 32;
    localparam int FIXED = 16;

    typedef struct packed {
        logic signed [BITS-1:0] x;
        logic signed [BITS-1:0] y;
        logic signed [BITS-1:0] z;
    } vec3_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POINT  = 3'd1,
        START  = 3'd2,
        WAIT   = 3'd3,
        EVAL   = 3'd4,
        RESULT = 3'd5
    } state_e;

    // Q16.16 product: both operands are signed, so the 64-bit product is a
    // true signed multiply; taking bits [FIXED +: BITS] equals (prod >>> 16)
    // truncated back to the word width.
    function automatic logic signed [BITS-1:0] fx_mul(
        input logic signed [BITS-1:0] a,
        input logic signed [BITS-1:0] b
    );
        logic signed [2*BITS-1:0] prod;
        prod = a * b;
        return prod[FIXED +: BITS];
    endfunction

    // Signed add with clamping. Positive overflow clamps to the largest
    // positive value; the negative clamp is defensive only.
    function automatic logic signed [BITS-1:0] sat_add(
        input logic signed [BITS-1:0] a,
        input logic signed [BITS-1:0] b
    );
        logic signed [BITS-1:0] sum;
        logic signed [BITS-1:0] res;
        sum = a + b;
        if (!a[BITS-1] && !b[BITS-1] && sum[BITS-1]) begin
            res = {1'b0, {(BITS-1){1'b1}}};
        end else if (a[BITS-1] && b[BITS-1] && !sum[BITS-1]) begin
            res = {1'b1, {(BITS-1){1'b0}}};
        end else begin
            res = sum;
        end
        return res;
    endfunction

endpackage

// File: rtl/raymarch_ctrl_ray_point.sv
// -----------------------------------------------------------------------------
// ray_point
// Combinational sample-point generator: p = org + ((t * dir) >>> 16) per axis.
// Ports:
//   org_in : ray origin (Q16.16 vec3)
//   dir_in : ray direction (Q16.16 vec3)
//   t_in   : current march distance (Q16.16)
//   p_out  : sample point (Q16.16 vec3), wraps on overflow
// -----------------------------------------------------------------------------
module ray_point
    import raymarch_pkg::*;
(
    input  vec3_t                  org_in,
    input  vec3_t                  dir_in,
    input  logic signed [BITS-1:0] t_in,
    output vec3_t                  p_out
);

    // Three independent fixed-point multiply-adds, one per axis.
    always_comb begin
        p_out   = '0;
        p_out.x = org_in.x + fx_mul(t_in, dir_in.x);
        p_out.y = org_in.y + fx_mul(t_in, dir_in.y);
        p_out.z = org_in.z + fx_mul(t_in, dir_in.z);
    end

endmodule

// File: rtl/raymarch_ctrl.sv
// -----------------------------------------------------------------------------
// raymarch_ctrl
// Sphere-tracing controller: accepts a ray, repeatedly asks an external SDF
// evaluator for the distance at p = org + t*dir, advances t by that distance
// and terminates on hit (dist < EPS), far miss (t+dist >= T_MAX) or step limit.
// Optional build macro: RAYMARCH_STATS_EN adds stat_cycles_out.
// Ports:
//   clk_in, rst_in                 : clock, async active-low reset
//   ray_valid_in / ray_ready_out   : ray accept handshake
//   org_*_in, dir_*_in             : ray origin / unit direction (Q16.16)
//   sdf_start_out, sdf_*_out       : evaluator command (one-cycle start pulse)
//   sdf_done_in, sdf_dist_in       : evaluator response
//   result_valid_out/result_ready_in: result handshake
//   hit_out, t_out, steps_out      : result payload
//   stat_cycles_out (optional)     : cycles from accept to result handshake
// -----------------------------------------------------------------------------
module raymarch_ctrl
    import raymarch_pkg::*;
#(
    parameter int              MAX_STEPS = 64,
    parameter logic [BITS-1:0] EPS       = 32'h0000_0020,
    parameter logic [BITS-1:0] T_MAX     = 32'h0064_0000
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   ray_valid_in,
    output logic                   ray_ready_out,
    input  logic signed [BITS-1:0] org_x_in,
    input  logic signed [BITS-1:0] org_y_in,
    input  logic signed [BITS-1:0] org_z_in,
    input  logic signed [BITS-1:0] dir_x_in,
    input  logic signed [BITS-1:0] dir_y_in,
    input  logic signed [BITS-1:0] dir_z_in,
    output logic                   sdf_start_out,
    output logic signed [BITS-1:0] sdf_x_out,
    output logic signed [BITS-1:0] sdf_y_out,
    output logic signed [BITS-1:0] sdf_z_out,
    input  logic                   sdf_done_in,
    input  logic signed [BITS-1:0] sdf_dist_in,
    output logic                   result_valid_out,
    input  logic                   result_ready_in,
    output logic                   hit_out,
    output logic signed [BITS-1:0] t_out,
    output logic [7:0]             steps_out
`ifdef RAYMARCH_STATS_EN
    ,
    output logic [31:0]            stat_cycles_out
`endif
);

    localparam logic [7:0] MAX_STEPS_C = 8'(MAX_STEPS);

    state_e                 state_q,        state_d;
    vec3_t                  org_q,          org_d;
    vec3_t                  dir_q,          dir_d;
    logic signed [BITS-1:0] t_q,            t_d;
    logic signed [BITS-1:0] dist_q,         dist_d;
    logic [7:0]             steps_q,        steps_d;
    vec3_t                  sdf_p_q,        sdf_p_d;
    logic                   sdf_start_q,    sdf_start_d;
    logic                   ray_ready_q,    ray_ready_d;
    logic                   result_valid_q, result_valid_d;
    logic                   hit_q,          hit_d;
    logic signed [BITS-1:0] t_out_q,        t_out_d;
    logic [7:0]             steps_out_q,    steps_out_d;

    vec3_t                  point_s;
    logic signed [BITS-1:0] sum_s;
    logic                   accept_s;

    ray_point u_ray_point (
        .org_in (org_q),
        .dir_in (dir_q),
        .t_in   (t_q),
        .p_out  (point_s)
    );

    assign sum_s    = sat_add(t_q, dist_q);
    assign accept_s = (state_q == IDLE) && ray_valid_in && ray_ready_q;

    // Next-state and datapath update for the march sequence.
    always_comb begin
        state_d     = state_q;
        org_d       = org_q;
        dir_d       = dir_q;
        t_d         = t_q;
        dist_d      = dist_q;
        steps_d     = steps_q;
        sdf_p_d     = sdf_p_q;
        hit_d       = hit_q;
        t_out_d     = t_out_q;
        steps_out_d = steps_out_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    org_d   = '{x: org_x_in, y: org_y_in, z: org_z_in};
                    dir_d   = '{x: dir_x_in, y: dir_y_in, z: dir_z_in};
                    t_d     = 32'sd0;
                    steps_d = 8'd0;
                    state_d = POINT;
                end else begin
                    state_d = IDLE;
                end
            end
            POINT: begin
                sdf_p_d = point_s;
                state_d = START;
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                // Responses are only meaningful here; anything earlier is stale.
                if (sdf_done_in) begin
                    dist_d  = sdf_dist_in;
                    steps_d = steps_q + 8'd1;
                    state_d = EVAL;
                end else begin
                    state_d = WAIT;
                end
            end
            EVAL: begin
                // Priority: hit, far miss, step limit, continue. A miss reports
                // the advanced (saturated) distance, a hit the pre-advance one.
                if (dist_q < $signed(EPS)) begin
                    hit_d       = 1'b1;
                    t_out_d     = t_q;
                    steps_out_d = steps_q;
                    state_d     = RESULT;
                end else if (sum_s >= $signed(T_MAX)) begin
                    hit_d       = 1'b0;
                    t_out_d     = sum_s;
                    steps_out_d = steps_q;
                    state_d     = RESULT;
                end else if (steps_q == MAX_STEPS_C) begin
                    hit_d       = 1'b0;
                    t_out_d     = sum_s;
                    steps_out_d = steps_q;
                    state_d     = RESULT;
                end else begin
                    t_d     = sum_s;
                    state_d = POINT;
                end
            end
            RESULT: begin
                if (result_ready_in && result_valid_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESULT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Handshake/strobe outputs are decoded from the next state so they
        // come straight out of flops aligned with the state they belong to.
        ray_ready_d    = (state_d == IDLE);
        sdf_start_d    = (state_d == START);
        result_valid_d = (state_d == RESULT);
    end

    // State and output registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q        <= IDLE;
            org_q          <= '0;
            dir_q          <= '0;
            t_q            <= 32'sd0;
            dist_q         <= 32'sd0;
            steps_q        <= 8'd0;
            sdf_p_q        <= '0;
            sdf_start_q    <= 1'b0;
            ray_ready_q    <= 1'b0;
            result_valid_q <= 1'b0;
            hit_q          <= 1'b0;
            t_out_q        <= 32'sd0;
            steps_out_q    <= 8'd0;
        end else begin
            state_q        <= state_d;
            org_q          <= org_d;
            dir_q          <= dir_d;
            t_q            <= t_d;
            dist_q         <= dist_d;
            steps_q        <= steps_d;
            sdf_p_q        <= sdf_p_d;
            sdf_start_q    <= sdf_start_d;
            ray_ready_q    <= ray_ready_d;
            result_valid_q <= result_valid_d;
            hit_q          <= hit_d;
            t_out_q        <= t_out_d;
            steps_out_q    <= steps_out_d;
        end
    end

    assign ray_ready_out    = ray_ready_q;
    assign sdf_start_out    = sdf_start_q;
    assign sdf_x_out        = sdf_p_q.x;
    assign sdf_y_out        = sdf_p_q.y;
    assign sdf_z_out        = sdf_p_q.z;
    assign result_valid_out = result_valid_q;
    assign hit_out          = hit_q;
    assign t_out            = t_out_q;
    assign steps_out        = steps_out_q;

`ifdef RAYMARCH_STATS_EN
    logic [31:0] stat_cycles_q, stat_cycles_d;

    // Busy-cycle counter: restarts on accept, frozen while idle.
    always_comb begin
        stat_cycles_d = stat_cycles_q;
        if (accept_s) begin
            stat_cycles_d = 32'd0;
        end else if (state_q != IDLE) begin
            stat_cycles_d = stat_cycles_q + 32'd1;
        end else begin
            stat_cycles_d = stat_cycles_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            stat_cycles_q <= 32'd0;
        end else begin
            stat_cycles_q <= stat_cycles_d;
        end
    end

    assign stat_cycles_out = stat_cycles_q;
`endif

endmodule

// File: tb/tb_raymarch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_raymarch_ctrl
// Directed bench for raymarch_ctrl. Two instances share all inputs: dut_a uses
// default parameters, dut_b raises T_MAX to 32'h7FFF_FFFF so the saturating add
// can be reached. A behavioural evaluator stub answers the selected instance.
// -----------------------------------------------------------------------------
module tb_raymarch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ray_valid;
    logic [31:0] org_x, org_y, org_z, dir_x, dir_y, dir_z;
    logic        sdf_done;
    logic [31:0] sdf_dist;
    logic        result_ready;
    logic        sel;

    logic        a_ready, a_start, a_rv, a_hit;
    logic [31:0] a_x, a_y, a_z, a_t;
    logic [7:0]  a_steps;
    logic        b_ready, b_start, b_rv, b_hit;
    logic [31:0] b_x, b_y, b_z, b_t;
    logic [7:0]  b_steps;
`ifdef RAYMARCH_STATS_EN
    logic [31:0] a_stat, b_stat;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    raymarch_ctrl dut_a (
        .clk_in(clk), .rst_in(rst_n),
        .ray_valid_in(ray_valid), .ray_ready_out(a_ready),
        .org_x_in(org_x), .org_y_in(org_y), .org_z_in(org_z),
        .dir_x_in(dir_x), .dir_y_in(dir_y), .dir_z_in(dir_z),
        .sdf_start_out(a_start), .sdf_x_out(a_x), .sdf_y_out(a_y), .sdf_z_out(a_z),
        .sdf_done_in(sdf_done), .sdf_dist_in(sdf_dist),
        .result_valid_out(a_rv), .result_ready_in(result_ready),
        .hit_out(a_hit), .t_out(a_t), .steps_out(a_steps)
`ifdef RAYMARCH_STATS_EN
        , .stat_cycles_out(a_stat)
`endif
    );

    raymarch_ctrl #(.T_MAX(32'h7FFF_FFFF)) dut_b (
        .clk_in(clk), .rst_in(rst_n),
        .ray_valid_in(ray_valid), .ray_ready_out(b_ready),
        .org_x_in(org_x), .org_y_in(org_y), .org_z_in(org_z),
        .dir_x_in(dir_x), .dir_y_in(dir_y), .dir_z_in(dir_z),
        .sdf_start_out(b_start), .sdf_x_out(b_x), .sdf_y_out(b_y), .sdf_z_out(b_z),
        .sdf_done_in(sdf_done), .sdf_dist_in(sdf_dist),
        .result_valid_out(b_rv), .result_ready_in(result_ready),
        .hit_out(b_hit), .t_out(b_t), .steps_out(b_steps)
`ifdef RAYMARCH_STATS_EN
        , .stat_cycles_out(b_stat)
`endif
    );

    // Observed outputs of the instance under test.
    wire        o_ready = sel ? b_ready : a_ready;
    wire        o_start = sel ? b_start : a_start;
    wire        o_rv    = sel ? b_rv    : a_rv;
    wire        o_hit   = sel ? b_hit   : a_hit;
    wire [31:0] o_x     = sel ? b_x     : a_x;
    wire [31:0] o_y     = sel ? b_y     : a_y;
    wire [31:0] o_z     = sel ? b_z     : a_z;
    wire [31:0] o_t     = sel ? b_t     : a_t;
    wire [7:0]  o_steps = sel ? b_steps : a_steps;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Unit-sphere SDF along z: |z| - 1.0
    function automatic logic [31:0] sphere_dist(input logic [31:0] z);
        logic signed [31:0] s;
        s = z;
        if (s < 0) s = -s;
        return s - 32'sd65536;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; ray_valid = 1'b0; sdf_done = 1'b0; result_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Present a ray, then act as evaluator until result_valid. Called at a negedge.
    task automatic run_ray(input logic [31:0] oz, input logic [31:0] dz, input bit sphere,
                           input logic [31:0] cval, input bit spur);
        int  cyc;
        bit  got;
        org_x = 32'h0; org_y = 32'h0; org_z = oz;
        dir_x = 32'h0; dir_y = 32'h0; dir_z = dz;
        ray_valid = 1'b1;
        cyc = 0;
        while (!o_ready && cyc < 50) begin @(negedge clk); cyc++; end
        @(posedge clk);
        @(negedge clk);
        ray_valid = 1'b0;
        if (spur) begin
            // DUT is in POINT now; a done pulse here must be ignored.
            sdf_done = 1'b1; sdf_dist = 32'h0;
            @(negedge clk);
            sdf_done = 1'b0;
        end
        got = 1'b0; cyc = 0;
        while (!got && cyc < 2000) begin
            if (o_rv) begin
                got = 1'b1;
            end else if (o_start) begin
                @(negedge clk);
                sdf_done = 1'b1;
                sdf_dist = sphere ? sphere_dist(o_z) : cval;
                @(negedge clk);
                sdf_done = 1'b0;
                cyc += 2;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        check_eq("result_seen", {31'b0, got}, 32'd1);
    endtask

    task automatic check_result(input string tag, input logic h, input logic [31:0] t,
                                input logic [7:0] s);
        check_eq({tag, "_hit"},   {31'b0, o_hit},  {31'b0, h});
        check_eq({tag, "_t"},     o_t,             t);
        check_eq({tag, "_steps"}, {24'b0, o_steps}, {24'b0, s});
    endtask

    task automatic handshake(input string tag);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        check_eq({tag, "_rv_low"},   {31'b0, o_rv},    32'd0);
        check_eq({tag, "_ready_hi"}, {31'b0, o_ready}, 32'd1);
    endtask

    // Directed sequence.
    initial begin
        int cyc;
        sel = 1'b0; sdf_dist = 32'h0;
        org_x = 32'h0; org_y = 32'h0; org_z = 32'h0;
        dir_x = 32'h0; dir_y = 32'h0; dir_z = 32'h0;
        rst_n = 1'b0; ray_valid = 1'b0; sdf_done = 1'b0; result_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", {31'b0, o_ready}, 32'd0);
        check_eq("rst_start", {31'b0, o_start}, 32'd0);
        check_eq("rst_rv",    {31'b0, o_rv},    32'd0);
        check_eq("rst_sdfz",  o_z,              32'd0);
        check_result("rst", 1'b0, 32'h0, 8'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rel_ready", {31'b0, o_ready}, 32'd1);

        // Sphere at z=-5: step1 dist 4.0, step2 dist 0 -> hit at t=4.0, spurious done in POINT
        run_ray(32'hFFFB_0000, 32'h0001_0000, 1'b1, 32'h0, 1'b1);
        check_result("sphere", 1'b1, 32'h0004_0000, 8'd2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("hold_rv",    {31'b0, o_rv},    32'd1);
            check_eq("hold_ready", {31'b0, o_ready}, 32'd0);
            check_result("hold", 1'b1, 32'h0004_0000, 8'd2);
        end
        check_eq("hold_sdfz", o_z, 32'hFFFF_0000);
        handshake("sphere");

        // Constant 1.0: step limit at 64, miss, t advanced to 64.0
        do_reset();
        run_ray(32'h0, 32'h0001_0000, 1'b0, 32'h0001_0000, 1'b0);
        check_result("steplim", 1'b0, 32'h0040_0000, 8'd64);
        handshake("steplim");

        // Negative distance on first step: hit at t=0
        do_reset();
        run_ray(32'h0, 32'h0001_0000, 1'b0, 32'hFFFF_8000, 1'b0);
        check_result("neg", 1'b1, 32'h0, 8'd1);
        handshake("neg");

        // 50.0 per step: t+dist == 100.0 on step 2 -> miss at boundary
        do_reset();
        run_ray(32'h0, 32'h0001_0000, 1'b0, 32'h0032_0000, 1'b0);
        check_result("tmax", 1'b0, 32'h0064_0000, 8'd2);
        handshake("tmax");

        // dist == EPS is not a hit: 64 steps of 0x20
        do_reset();
        run_ray(32'h0, 32'h0001_0000, 1'b0, 32'h0000_0020, 1'b0);
        check_result("eps_eq", 1'b0, 32'h0000_0800, 8'd64);
        handshake("eps_eq");

        // dist == EPS-1 is a hit
        do_reset();
        run_ray(32'h0, 32'h0001_0000, 1'b0, 32'h0000_001F, 1'b0);
        check_result("eps_lt", 1'b1, 32'h0, 8'd1);
        handshake("eps_lt");

        // Saturation on the wide-T_MAX instance
        do_reset();
        sel = 1'b1;
        run_ray(32'h0, 32'h0001_0000, 1'b0, 32'h7FFF_0000, 1'b0);
        check_result("sat", 1'b0, 32'h7FFF_FFFF, 8'd2);
        handshake("sat");
        sel = 1'b0;

        // Reset while waiting on the evaluator
        do_reset();
        org_z = 32'hFFFB_0000; dir_z = 32'h0001_0000;
        ray_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ray_valid = 1'b0;
        cyc = 0;
        while (!o_start && cyc < 20) begin @(negedge clk); cyc++; end
        check_eq("mid_start_seen", {31'b0, o_start}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("mid_ready", {31'b0, o_ready}, 32'd0);
        check_eq("mid_start", {31'b0, o_start}, 32'd0);
        check_eq("mid_rv",    {31'b0, o_rv},    32'd0);
        check_eq("mid_sdfz",  o_z,              32'd0);
        check_result("mid", 1'b0, 32'h0, 8'd0);
        sdf_done = 1'b1; sdf_dist = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("late_ready", {31'b0, o_ready}, 32'd1);
        check_eq("late_start", {31'b0, o_start}, 32'd0);
        check_eq("late_rv",    {31'b0, o_rv},    32'd0);
        sdf_done = 1'b0;
        run_ray(32'hFFFB_0000, 32'h0001_0000, 1'b1, 32'h0, 1'b0);
        check_result("after_rst", 1'b1, 32'h0004_0000, 8'd2);
        handshake("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/raymarch_ctrl.md
RAYMARCH_CTRL -- requirements
Module: raymarch_ctrl

Interface
REQ-001 SHALL have parameter MAX_STEPS, default 64, max march iterations per ray (1..255).
REQ-002 SHALL have parameter EPS, default 32'h0000_0020, Q16.16 hit threshold.
REQ-003 SHALL have parameter T_MAX, default 32'h0064_0000 (100.0), Q16.16 miss distance.
REQ-004 SHALL have port clk_in  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_in  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have ports ray_valid_in input 1 and ray_ready_out output 1, the ray-accept handshake.
REQ-007 SHALL have ports org_x_in, org_y_in, org_z_in, each input 32 signed Q16.16, the ray origin.
REQ-008 SHALL have ports dir_x_in, dir_y_in, dir_z_in, each input 32 signed Q16.16, the unit ray direction.
REQ-009 SHALL have ports sdf_start_out output 1 and sdf_x_out, sdf_y_out, sdf_z_out output 32 signed, the evaluator command.
REQ-010 SHALL have ports sdf_done_in input 1 and sdf_dist_in input 32 signed, the evaluator response.
REQ-011 SHALL have ports result_valid_out output 1 and result_ready_in input 1, the result handshake.
REQ-012 SHALL have ports hit_out output 1, t_out output 32 signed and steps_out output 8, the result payload.

Function
REQ-013 SHALL implement states IDLE, POINT, START, WAIT, EVAL, RESULT.
REQ-014 SHALL assert ray_ready_out only in IDLE; on valid&&ready, latch origin/dir, clear t and steps, and go to POINT.
REQ-015 SHALL in POINT compute p = org + ((t*dir)>>>16) per axis, 64-bit product, truncated to 32 bits; register it to sdf_*_out; go to START next cycle.
REQ-016 SHALL pulse sdf_start_out high for exactly one cycle in START, hold sdf_*_out stable until sdf_done_in, then enter WAIT.
REQ-017 SHALL ignore sdf_done_in in every state except WAIT; in WAIT, on sdf_done_in, latch sdf_dist_in, increment steps and go to EVAL.
REQ-018 SHALL in EVAL apply, by priority: dist < EPS (including negative) -> hit=1; else t+dist >= T_MAX -> hit=0; else steps == MAX_STEPS -> hit=0; else t += dist and go to POINT.
REQ-019 SHALL saturate t+dist at 32'h7FFF_FFFF on signed overflow, which then resolves as a miss.
REQ-020 SHALL on termination go to RESULT with t_out = t at termination (the pre-add t on hit) and steps_out = steps.
REQ-021 SHALL hold result_valid_out and the payload stable in RESULT until result_ready_in, then return to IDLE in the same cycle as the handshake.
REQ-022 SHALL have minimum per-step overhead of 4 cycles (POINT, START, WAIT≥1, EVAL) plus evaluator latency.

Reset
REQ-023 SHALL on rst_in low, including mid-march, immediately enter IDLE; clear sdf_start_out, result_valid_out, hit_out, t_out, steps_out and sdf_*_out to 0; and drive ray_ready_out to 1 after release.
REQ-024 SHALL drop any in-flight evaluator response after reset.

Configuration
REQ-025 SHALL, with RAYMARCH_STATS_EN defined, add output stat_cycles_out (32 bits) counting cycles from ray accept to result handshake, cleared on accept and held in IDLE.
REQ-026 SHALL, without RAYMARCH_STATS_EN, omit the port and its counter entirely.

Structure
REQ-027 SHALL take BITS=32, FIXED=16, the vec3 struct and the state enum from shared package raymarch_pkg.
REQ-028 SHALL place the point computation (three fixed multiplies plus adds) in sub-module ray_point.

Verification
REQ-029 SHALL cover: origin (0,0,-5.0), dir (0,0,1.0), stub returns dist = |z|-1.0 -> hit_out=1, t_out ~= 4.0, steps_out small, exact value per stub.
REQ-030 SHALL cover: stub always returns 1.0 -> miss at t+dist >= 100.0, hit_out=0, steps_out=64 limited by MAX_STEPS first (64 < 100).
REQ-031 SHALL cover: stub returns -0.5 on first step -> hit_out=1, t_out=0, steps_out=1.
REQ-032 SHALL cover: stub returns 32'h7FFF_0000 twice -> saturation, hit_out=0, steps_out=2.
REQ-033 SHALL cover: result_ready_in held low 10 cycles -> payload stable, ray_ready_out=0; spurious sdf_done_in in POINT ignored.
REQ-034 SHALL cover: rst_in asserted during WAIT -> all outputs 0 same cycle, late sdf_done_in ignored, next ray processes normally.
